// File: rtl/ecc_pkg.sv
// Shared widths and FSM encoding for the ECC scrubber; no logic, no latency.
// Imported by the scrubber top; carries no handshake of its own.
package ecc_pkg;
    localparam int DATA_W = 64;
    localparam int CODE_W = 72;

    typedef enum logic [2:0] {
        IDLE, WAIT, RD_REQ, RD_WAIT, DECODE, ENCODE, WR_REQ, NEXT
    } scrub_state_t;
endpackage

// File: rtl/scrub_lat_timer.sv
// Loadable down-counter, 1-cycle load, o_zero true while count is zero.
// No backpressure: load wins over decrement, count holds at zero.
module scrub_lat_timer #(
    parameter int W = 16
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_zero
);
    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);
endmodule

// File: rtl/ecc_scrub_ctrl.sv
// Background ECC scrubber: read, decode, rewrite corrected words, log double errors; all outputs registered.
// Memory requests are held with stable address/data until mem_gnt; read data accepted whenever rvalid arrives.
module ecc_scrub_ctrl
    import ecc_pkg::*;
#(
    parameter int ADDR_W     = 10,
    parameter int INTERVAL_W = 16,
    parameter int CNT_W      = 16,
    parameter int DEC_LAT    = 1,
    parameter int ENC_LAT    = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_enable,
    input  logic [INTERVAL_W-1:0] i_interval,
    output logic                  o_mem_req,
    output logic                  o_mem_we,
    output logic [ADDR_W-1:0]     o_mem_addr,
    output logic [CODE_W-1:0]     o_mem_wdata,
    input  logic                  i_mem_gnt,
    input  logic                  i_mem_rvalid,
    input  logic [CODE_W-1:0]     i_mem_rdata,
    output logic [CODE_W-1:0]     o_dec_data_in,
    input  logic [CODE_W-1:0]     i_dec_data_out,
    input  logic                  i_dec_single,
    input  logic                  i_dec_double,
    output logic [DATA_W-1:0]     o_enc_data_in,
    input  logic [CODE_W-1:0]     i_enc_data_out,
    output logic [CNT_W-1:0]      o_sbe_count,
    output logic [CNT_W-1:0]      o_dbe_count,
    output logic [ADDR_W-1:0]     o_dbe_addr,
    output logic                  o_dbe_irq,
    output logic                  o_pass_done,
    output logic                  o_busy
);
    scrub_state_t          r_state;
    logic                  r_wait_armed;
    logic [ADDR_W-1:0]     r_addr;
    logic                  r_mem_req;
    logic                  r_mem_we;
    logic [CODE_W-1:0]     r_mem_wdata;
    logic [CODE_W-1:0]     r_dec_data_in;
    logic [DATA_W-1:0]     r_enc_data_in;
    logic [CNT_W-1:0]      r_sbe_count;
    logic [CNT_W-1:0]      r_dbe_count;
    logic [ADDR_W-1:0]     r_dbe_addr;
    logic                  r_dbe_irq;
    logic                  r_pass_done;
    logic                  r_busy;

    logic                  w_tmr_load;
    logic [INTERVAL_W-1:0] w_tmr_val;
    logic                  w_tmr_zero;
    logic                  w_last;
    logic                  w_unused_dec;

    assign w_last       = (r_addr == '1);
    assign w_unused_dec = ^i_dec_data_out[CODE_W-1:DATA_W];

    // One timer serves the idle interval and both pipeline latencies; each is loaded on state entry.
    always_comb begin
        w_tmr_load = 1'b0;
        w_tmr_val  = '0;
        case (r_state)
            WAIT: begin
                if (i_enable && !r_wait_armed && (i_interval != '0)) begin
                    w_tmr_load = 1'b1;
                    w_tmr_val  = i_interval - 1'b1;
                end
            end
            RD_WAIT: begin
                if (i_mem_rvalid) begin
                    w_tmr_load = 1'b1;
                    w_tmr_val  = INTERVAL_W'(DEC_LAT);
                end
            end
            DECODE: begin
                if (w_tmr_zero && !i_dec_double && i_dec_single) begin
                    w_tmr_load = 1'b1;
                    w_tmr_val  = INTERVAL_W'(ENC_LAT);
                end
            end
            default: ;
        endcase
    end

    scrub_lat_timer #(.W(INTERVAL_W)) u_timer (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .o_zero     (w_tmr_zero)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= IDLE;
            r_wait_armed  <= 1'b0;
            r_addr        <= '0;
            r_mem_req     <= 1'b0;
            r_mem_we      <= 1'b0;
            r_mem_wdata   <= '0;
            r_dec_data_in <= '0;
            r_enc_data_in <= '0;
            r_sbe_count   <= '0;
            r_dbe_count   <= '0;
            r_dbe_addr    <= '0;
            r_dbe_irq     <= 1'b0;
            r_pass_done   <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_dbe_irq   <= 1'b0;
            r_pass_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_enable) begin
                        r_state <= WAIT;
                        r_busy  <= 1'b1;
                    end
                end
                WAIT: begin
                    if (!i_enable) begin
                        r_state      <= IDLE;
                        r_busy       <= 1'b0;
                        r_wait_armed <= 1'b0;
                    end else if (r_wait_armed ? w_tmr_zero : (i_interval == '0)) begin
                        r_state      <= RD_REQ;
                        r_wait_armed <= 1'b0;
                        r_mem_req    <= 1'b1;
                        r_mem_we     <= 1'b0;
                    end else begin
                        r_wait_armed <= 1'b1;
                    end
                end
                RD_REQ: begin
                    if (i_mem_gnt) begin
                        r_mem_req <= 1'b0;
                        r_state   <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (i_mem_rvalid) begin
                        r_dec_data_in <= i_mem_rdata;
                        r_state       <= DECODE;
                    end
                end
                DECODE: begin
                    if (w_tmr_zero) begin
                        if (i_dec_double) begin
                            if (r_dbe_count != '1) r_dbe_count <= r_dbe_count + 1'b1;
                            r_dbe_addr  <= r_addr;
                            r_dbe_irq   <= 1'b1;
                            r_pass_done <= w_last;
                            r_state     <= NEXT;
                        end else if (i_dec_single) begin
                            r_enc_data_in <= i_dec_data_out[DATA_W-1:0];
                            r_state       <= ENCODE;
                        end else begin
                            r_pass_done <= w_last;
                            r_state     <= NEXT;
                        end
                    end
                end
                ENCODE: begin
                    if (w_tmr_zero) begin
                        r_mem_wdata <= i_enc_data_out;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= 1'b1;
                        r_state     <= WR_REQ;
                    end
                end
                WR_REQ: begin
                    if (i_mem_gnt) begin
                        r_mem_req   <= 1'b0;
                        r_mem_we    <= 1'b0;
                        if (r_sbe_count != '1) r_sbe_count <= r_sbe_count + 1'b1;
                        r_pass_done <= w_last;
                        r_state     <= NEXT;
                    end
                end
                NEXT: begin
                    r_addr <= r_addr + 1'b1;
                    if (i_enable) begin
                        r_state <= WAIT;
                    end else begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_mem_req     = r_mem_req;
    assign o_mem_we      = r_mem_we;
    assign o_mem_addr    = r_addr;
    assign o_mem_wdata   = r_mem_wdata;
    assign o_dec_data_in = r_dec_data_in;
    assign o_enc_data_in = r_enc_data_in;
    assign o_sbe_count   = r_sbe_count;
    assign o_dbe_count   = r_dbe_count;
    assign o_dbe_addr    = r_dbe_addr;
    assign o_dbe_irq     = r_dbe_irq;
    assign o_pass_done   = r_pass_done;
    assign o_busy        = r_busy;
endmodule

// File: tb/tb_ecc_scrub_ctrl.sv
// Scrubber bench: 8-word memory with stallable grant, SECDED encoder/decoder models, write scoreboard.
module tb_ecc_scrub_ctrl;
    import ecc_pkg::*;

    localparam int AW = 3;

    logic                  clk = 1'b0;
    logic                  i_rst, i_enable;
    logic [15:0]           i_interval;
    logic                  o_mem_req, o_mem_we;
    logic [AW-1:0]         o_mem_addr;
    logic [CODE_W-1:0]     o_mem_wdata;
    logic                  i_mem_gnt, i_mem_rvalid;
    logic [CODE_W-1:0]     i_mem_rdata;
    logic [CODE_W-1:0]     o_dec_data_in, i_dec_data_out;
    logic                  i_dec_single, i_dec_double;
    logic [DATA_W-1:0]     o_enc_data_in;
    logic [CODE_W-1:0]     i_enc_data_out;
    logic [15:0]           o_sbe_count, o_dbe_count;
    logic [AW-1:0]         o_dbe_addr;
    logic                  o_dbe_irq, o_pass_done, o_busy;

    always #5 clk = ~clk;

    ecc_scrub_ctrl #(.ADDR_W(AW), .INTERVAL_W(16), .CNT_W(16), .DEC_LAT(1), .ENC_LAT(1)) dut (
        .i_clk(clk), .i_rst(i_rst), .i_enable(i_enable), .i_interval(i_interval),
        .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
        .o_mem_wdata(o_mem_wdata), .i_mem_gnt(i_mem_gnt), .i_mem_rvalid(i_mem_rvalid),
        .i_mem_rdata(i_mem_rdata), .o_dec_data_in(o_dec_data_in), .i_dec_data_out(i_dec_data_out),
        .i_dec_single(i_dec_single), .i_dec_double(i_dec_double), .o_enc_data_in(o_enc_data_in),
        .i_enc_data_out(i_enc_data_out), .o_sbe_count(o_sbe_count), .o_dbe_count(o_dbe_count),
        .o_dbe_addr(o_dbe_addr), .o_dbe_irq(o_dbe_irq), .o_pass_done(o_pass_done), .o_busy(o_busy)
    );

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Hamming position (non power of two, 3..71) of payload bit j
    function automatic logic [6:0] hpos(input int j);
        int n;
        logic [6:0] res;
        n = -1;
        res = '0;
        for (int p = 3; p < 72; p++) begin
            if ((p & (p - 1)) != 0) begin
                n++;
                if (n == j) res = 7'(p);
            end
        end
        return res;
    endfunction

    // Systematic layout: [63:0] payload, [70:64] Hamming checks, [71] overall parity
    function automatic logic [CODE_W-1:0] secded_enc(input logic [DATA_W-1:0] d);
        logic [6:0] s;
        s = '0;
        for (int j = 0; j < 64; j++) if (d[j]) s ^= hpos(j);
        return {^{s, d}, s, d};
    endfunction

    function automatic logic [CODE_W+1:0] secded_dec(input logic [CODE_W-1:0] cw);
        logic [6:0] s;
        logic [CODE_W-1:0] c;
        logic sg, db, found;
        s = '0;
        for (int j = 0; j < 64; j++) if (cw[j]) s ^= hpos(j);
        for (int k = 0; k < 7; k++) if (cw[64+k]) s ^= 7'(1 << k);
        c = cw; sg = 1'b0; db = 1'b0; found = 1'b0;
        if (^cw) begin
            sg = 1'b1;
            if (s == 7'd0) begin
                c[71] = ~c[71];
            end else if ((s & (s - 7'd1)) == 7'd0) begin
                for (int k = 0; k < 7; k++) if (s == 7'(1 << k)) c[64+k] = ~c[64+k];
            end else begin
                for (int j = 0; j < 64; j++) if (hpos(j) == s) begin c[j] = ~c[j]; found = 1'b1; end
                if (!found) begin sg = 1'b0; db = 1'b1; end
            end
        end else if (s != 7'd0) begin
            db = 1'b1;
        end
        return {db, sg, c};
    endfunction

    always_ff @(posedge clk) begin
        {i_dec_double, i_dec_single, i_dec_data_out} <= secded_dec(o_dec_data_in);
        i_enc_data_out <= secded_enc(o_enc_data_in);
    end

    function automatic logic [DATA_W-1:0] pat(input int a);
        return {56'h00C0FFEE123456, 8'(a)};
    endfunction

    typedef struct packed {
        logic [AW-1:0]     addr;
        logic [CODE_W-1:0] data;
    } wr_t;
    wr_t exp_q[$];

    logic [CODE_W-1:0] mem [0:7];
    int   stall_cfg = 0, stall = 0, rd_cnt = 0, wr_cnt = 0, pass_cnt = 0, irq_cnt = 0, irq_wide = 0;
    logic req_seen = 1'b0, prev_irq = 1'b0, rd_pend = 1'b0, cap_we;
    logic [AW-1:0]     cap_addr;
    logic [CODE_W-1:0] cap_wdata, rd_data;

    task automatic push_exp(input logic [AW-1:0] a, input logic [CODE_W-1:0] d);
        wr_t w;
        w.addr = a;
        w.data = d;
        exp_q.push_back(w);
    endtask

    // Memory port: grant after stall_cfg cycles of request, read data one cycle after grant
    initial begin
        wr_t w;
        i_mem_gnt = 1'b0; i_mem_rvalid = 1'b0; i_mem_rdata = '0;
        forever begin
            @(negedge clk);
            i_mem_rvalid = rd_pend;
            i_mem_rdata  = rd_pend ? rd_data : '0;
            rd_pend      = 1'b0;
            i_mem_gnt    = 1'b0;
            if (o_pass_done) pass_cnt++;
            if (o_dbe_irq) begin
                irq_cnt++;
                if (prev_irq) irq_wide++;
            end
            prev_irq = o_dbe_irq;
            if (i_rst) begin
                req_seen = 1'b0;
                stall    = 0;
            end else if (o_mem_req) begin
                if (!req_seen) begin
                    req_seen = 1'b1; cap_addr = o_mem_addr; cap_we = o_mem_we; cap_wdata = o_mem_wdata;
                    stall = stall_cfg;
                end else begin
                    chk("req_addr_stable", o_mem_addr, cap_addr);
                    chk("req_we_stable", o_mem_we, cap_we);
                    if (o_mem_we) chk("req_wdata_stable", o_mem_wdata, cap_wdata);
                end
                if (stall > 0) begin
                    stall--;
                end else begin
                    i_mem_gnt = 1'b1;
                    req_seen  = 1'b0;
                    if (o_mem_we) begin
                        wr_cnt++;
                        mem[o_mem_addr] = o_mem_wdata;
                        chk("write_was_expected", exp_q.size() != 0, 1'b1);
                        if (exp_q.size() != 0) begin
                            w = exp_q.pop_front();
                            chk("write_addr", o_mem_addr, w.addr);
                            chk("write_data", o_mem_wdata, w.data);
                        end
                    end else begin
                        rd_cnt++;
                        rd_pend = 1'b1;
                        rd_data = mem[o_mem_addr];
                    end
                end
            end else if (req_seen) begin
                chk("req_held_until_gnt", o_mem_req, 1'b1);
                req_seen = 1'b0;
            end
        end
    end

    task automatic wait_pass(input string tag);
        logic seen;
        seen = 1'b0;
        i_enable = 1'b1;
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(negedge clk);
            seen = o_pass_done;
        end
        chk(tag, seen, 1'b1);
        i_enable = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;
        int   rd_before;
        i_rst = 1'b1; i_enable = 1'b0; i_interval = '0;
        for (int a = 0; a < 8; a++) mem[a] = secded_enc(pat(a));
        repeat (3) @(negedge clk);
        chk("rst_mem_req", o_mem_req, 1'b0);
        chk("rst_busy", o_busy, 1'b0);
        chk("rst_sbe", o_sbe_count, 16'd0);
        chk("rst_dbe", o_dbe_count, 16'd0);
        chk("rst_dbe_addr", o_dbe_addr, 3'd0);
        chk("rst_irq", o_dbe_irq, 1'b0);
        chk("rst_pass_done", o_pass_done, 1'b0);
        chk("rst_addr", o_mem_addr, 3'd0);
        i_rst = 1'b0;
        @(negedge clk);

        wait_pass("clean_pass_done");
        chk("clean_reads", rd_cnt, 8);
        chk("clean_writes", wr_cnt, 0);
        chk("clean_pass_pulses", pass_cnt, 1);
        chk("clean_sbe", o_sbe_count, 16'd0);
        chk("clean_dbe", o_dbe_count, 16'd0);
        chk("clean_idle", o_busy, 1'b0);
        chk("clean_addr_wrap", o_mem_addr, 3'd0);

        mem[5] = secded_enc(64'hDEADBEEF_CAFECAFE) ^ (72'd1 << 3);
        push_exp(3'd5, secded_enc(64'hDEADBEEF_CAFECAFE));
        wait_pass("sbe_pass_done");
        chk("sbe_writes", wr_cnt, 1);
        chk("sbe_count", o_sbe_count, 16'd1);
        chk("sbe_mem5", mem[5], secded_enc(64'hDEADBEEF_CAFECAFE));
        chk("sbe_queue_empty", exp_q.size(), 0);

        wait_pass("readback_pass_done");
        chk("readback_writes", wr_cnt, 1);
        chk("readback_sbe", o_sbe_count, 16'd1);
        chk("readback_dbe", o_dbe_count, 16'd0);

        mem[2] = mem[2] ^ 72'h201;
        wait_pass("dbe_pass_done");
        chk("dbe_count", o_dbe_count, 16'd1);
        chk("dbe_addr", o_dbe_addr, 3'd2);
        chk("dbe_irq_pulses", irq_cnt, 1);
        chk("dbe_irq_single_cycle", irq_wide, 0);
        chk("dbe_no_write", wr_cnt, 1);
        chk("dbe_sbe_unchanged", o_sbe_count, 16'd1);
        mem[2] = secded_enc(pat(2));

        stall_cfg = 4; i_interval = 16'd2;
        mem[6] = mem[6] ^ (72'd1 << 40);
        push_exp(3'd6, secded_enc(pat(6)));
        wait_pass("stall_pass_done");
        chk("stall_writes", wr_cnt, 2);
        chk("stall_sbe", o_sbe_count, 16'd2);
        chk("stall_reads", rd_cnt, 40);
        chk("stall_mem6", mem[6], secded_enc(pat(6)));
        chk("stall_queue_empty", exp_q.size(), 0);
        stall_cfg = 0; i_interval = '0;

        mem[3] = mem[3] ^ (72'd1 << 70);
        push_exp(3'd3, secded_enc(pat(3)));
        i_enable = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 500 && !seen; i++) begin
            @(negedge clk);
            seen = i_dec_single && (o_mem_addr == 3'd3);
        end
        chk("encode_reached", seen, 1'b1);
        @(negedge clk);
        i_enable = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            seen = !o_busy;
        end
        chk("encode_stop_idle", seen, 1'b1);
        chk("encode_stop_addr", o_mem_addr, 3'd4);
        chk("encode_stop_writes", wr_cnt, 3);
        chk("encode_stop_sbe", o_sbe_count, 16'd3);
        chk("encode_stop_mem3", mem[3], secded_enc(pat(3)));
        rd_before = rd_cnt;
        repeat (10) @(negedge clk);
        chk("encode_stop_no_reads", rd_cnt, rd_before);

        mem[4] = mem[4] ^ (72'd1 << 17);
        stall_cfg = 4;
        i_enable = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 500 && !seen; i++) begin
            @(negedge clk);
            seen = o_mem_req && o_mem_we;
        end
        chk("wr_req_reached", seen, 1'b1);
        i_rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_mem_req", o_mem_req, 1'b0);
        chk("mid_rst_busy", o_busy, 1'b0);
        chk("mid_rst_sbe", o_sbe_count, 16'd0);
        chk("mid_rst_dbe", o_dbe_count, 16'd0);
        chk("mid_rst_dbe_addr", o_dbe_addr, 3'd0);
        chk("mid_rst_addr", o_mem_addr, 3'd0);
        chk("mid_rst_no_write", wr_cnt, 3);
        i_enable = 1'b0; stall_cfg = 0;
        repeat (2) @(negedge clk);
        i_rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("final_queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
